// File: rtl/decoder_sweep_pkg.sv
// Shared types and defaults for the decoder sweep block.
package decoder_sweep_pkg;

    // Default select width; anything that needs the same decode span imports this.
    localparam int SEL_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_sweep_decoder_n.sv
// Parametrised SEL_W-to-2**SEL_W one-hot decoder with enable; all-zero when disabled.
module decoder_n #(
    parameter int SEL_W = 5
) (
    input  logic               en_i,
    input  logic [SEL_W-1:0]   idx_i,
    output logic [2**SEL_W-1:0] dec_o
);

    // Index always lands inside the vector because it spans the full select range.
    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_sweep.sv
// Registered decoder with an automatic one-hot sweep over every output bit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | direct decode of sel when en is high; sweep_start enters SWEEP
// SWEEP | walk one-hot d from bit 0 upward; sweep_hold freezes the walk
// DONE  | one-cycle completion pulse, d cleared, then back to IDLE
module decoder_sweep
    import decoder_sweep_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sweep_start,
    input  logic                sweep_hold,
    output logic [2**SEL_W-1:0] d,
    output logic                busy,
    output logic                done
);

    localparam int OUT_W = 2**SEL_W;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   d_q, d_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               dec_en;
    logic [SEL_W-1:0]   dec_idx;

    // One decoder serves both direct decode and the sweep; the FSM picks its index.
    decoder_n #(.SEL_W(SEL_W)) u_dec (
        .en_i  (dec_en),
        .idx_i (dec_idx),
        .dec_o (d_d)
    );

    // Next-state logic: every output is computed here and registered below,
    // so nothing on the inputs reaches d/busy/done without a flop in between.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dec_en  = 1'b0;
        dec_idx = '0;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dec_en  = 1'b1;
                    dec_idx = '0;
                end else begin
                    dec_en  = en;
                    dec_idx = sel;
                end
            end
            SWEEP: begin
                if (sweep_hold) begin
                    busy_d  = 1'b1;
                    dec_en  = 1'b1;
                    dec_idx = cnt_q;
                end else if (cnt_q == SEL_W'(OUT_W - 1)) begin
                    // Last bit already shown; the decoder stays disabled so d clears.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + SEL_W'(1);
                    busy_d  = 1'b1;
                    dec_en  = 1'b1;
                    dec_idx = cnt_q + SEL_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d    = d_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/decoder_sweep.md
DECODER_SWEEP -- requirements
Module: decoder_sweep

Interface
REQ-001 SHALL have parameter SEL_W, default 5, selects width; legal range 1..6.
REQ-002 SHALL have localparam OUT_W, value 2**SEL_W, decoded output width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  direct-decode enable, sampled in IDLE only.
REQ-006 SHALL have port sel  input  SEL_W  direct-decode index.
REQ-007 SHALL have port sweep_start  input  1  request an automatic walk over all outputs.
REQ-008 SHALL have port sweep_hold  input  1  pauses an active sweep.
REQ-009 SHALL have port d  output  OUT_W  registered one-hot or all-zero select vector.
REQ-010 SHALL have port busy  output  1  high while state is SWEEP.
REQ-011 SHALL have port done  output  1  single-cycle sweep-complete pulse.

Function
REQ-012 SHALL implement three states: IDLE, SWEEP, DONE; d, busy and done SHALL be registered, with no combinational input-to-output path.
REQ-013 In IDLE with sweep_start low: next d = en ? (1 << sel) : 0; latency exactly one cycle; busy = 0, done = 0.
REQ-014 In IDLE with sweep_start high, go to SWEEP: next d = bit 0 only, internal counter = 0, busy = 1. en and sel SHALL be ignored that cycle, so sweep_start has priority over en.
REQ-015 In SWEEP with sweep_hold low: the counter SHALL increment by 1 each cycle and d = 1 << counter.
REQ-016 In SWEEP with sweep_hold high: the counter and d SHALL hold their values.
REQ-017 In SWEEP, en, sel and sweep_start SHALL be ignored; a re-issued sweep_start SHALL NOT restart the sweep.
REQ-018 When the counter = OUT_W-1 and sweep_hold is low, go to DONE: next d = 0, busy = 0, done = 1.
REQ-019 An unheld sweep SHALL assert each output bit exactly once, for exactly one cycle, in ascending order: OUT_W cycles of busy, then one cycle of done.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; sweep_start and en in DONE SHALL be ignored; d = 0 during the cycle after DONE unless IDLE decoding applies.
REQ-021 d SHALL always be zero or one-hot, never multi-hot, in every state.
REQ-022 The counter SHALL be SEL_W bits wide and SHALL never wrap inside a sweep. With SEL_W=1, a sweep lasts 2 cycles.

Reset
REQ-023 With reset high at a clock edge: state = IDLE, counter = 0, d = 0, busy = 0, done = 0.
REQ-024 Reset SHALL override all other inputs, including during a SWEEP or DONE cycle; there is no partial-sweep resume.
REQ-025 On the first cycle after reset is released, IDLE decoding SHALL apply normally.

Structure
REQ-026 A shared package SHALL hold the state enum typedef (IDLE, SWEEP, DONE) and the default SEL_W constant; the CPU register file SHALL import the same constant.
REQ-027 One sub-module, decoder_n, SHALL be used: a parametrised combinational SEL_W-to-OUT_W decoder with enable, instantiated once and fed by a mux of sel or the counter.
REQ-028 Total RTL SHALL be 120-400 lines, including decoder_n.

Verification
REQ-029 Direct decode, SEL_W=2: en=1, sel = 0,1,2,3 on consecutive cycles -> d = 0001, 0010, 0100, 1000, each one cycle later; en=0 -> d = 0000 one cycle later.
REQ-030 Full sweep, SEL_W=5: one-cycle sweep_start pulse -> busy high for 32 cycles with d walking from bit 0 to bit 31, then done=1 with d=0 for 1 cycle, then IDLE.
REQ-031 Hold, SEL_W=2: sweep_hold high for 3 cycles while d=0100 -> d remains 0100 for 3 extra cycles; total busy = 7 cycles.
REQ-032 Priority: sweep_start=1 with en=1, sel=3 in IDLE -> next d = 0001 (not 1000), busy=1; sweep_start re-pulsed mid-sweep -> no restart.
REQ-033 Reset mid-sweep: reset at counter=2 -> next cycle d=0, busy=0, done=0; the following cycle en=1, sel=1 -> d=0010.
REQ-034 Every test SHALL assert each cycle that $countones(d) <= 1 and that done is never high in two consecutive cycles.
